// File: rtl/pixel_binarizer.sv
// Binarizes 8-bit grayscale pixels against a frame-synchronous threshold and counts foreground per frame.
// Fixed 2-cycle pixel latency; no backpressure, so bubbles simply propagate as pixel_valid_out = 0.
module pixel_binarizer #(
    parameter logic [7:0] INIT_THRESHOLD = 8'd128,
    parameter logic [7:0] MIN_THRESHOLD  = 8'd5,
    parameter logic [7:0] MAX_THRESHOLD  = 8'd250,
    parameter int         HWIDTH         = 11,
    parameter int         VWIDTH         = 10,
    parameter int         COUNT_WIDTH    = 20
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [7:0]             threshold_in,
    input  logic                   threshold_valid_in,
    input  logic [7:0]             pixel_in,
    input  logic                   pixel_valid_in,
    input  logic                   frame_start_in,
    input  logic [HWIDTH-1:0]      hcount_in,
    input  logic [VWIDTH-1:0]      vcount_in,
    output logic                   pixel_out,
    output logic                   pixel_valid_out,
    output logic [HWIDTH-1:0]      hcount_out,
    output logic [VWIDTH-1:0]      vcount_out,
    output logic [7:0]             threshold_out,
    output logic [7:0]             active_threshold_out,
    output logic                   update_pending_out,
    output logic [COUNT_WIDTH-1:0] ones_count_out,
    output logic                   frame_done_out
);

    logic [7:0]             shadow;
    logic [7:0]             active;
    logic                   pending;
    logic                   seen_frame;
    logic [COUNT_WIDTH-1:0] fg_count;

    logic                   s1_vld;
    logic                   s1_fs;
    logic [7:0]             s1_pix;
    logic [7:0]             s1_thr;
    logic [HWIDTH-1:0]      s1_h;
    logic [VWIDTH-1:0]      s1_v;

    logic [7:0] clamped;
    logic       promote;
    logic [7:0] thr_sel;
    logic       s1_res;

    always_comb begin
        clamped = threshold_in;
        if (threshold_in < MIN_THRESHOLD) begin
            clamped = MIN_THRESHOLD;
        end else if (threshold_in > MAX_THRESHOLD) begin
            clamped = MAX_THRESHOLD;
        end
        promote = pixel_valid_in && frame_start_in && pending;
        // The promoting pixel bypasses to the shadow so the whole frame sees one threshold.
        thr_sel = promote ? shadow : active;
        s1_res  = s1_vld && (s1_pix >= s1_thr);
    end

    assign threshold_out        = shadow;
    assign active_threshold_out = active;
    assign update_pending_out   = pending;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            shadow          <= INIT_THRESHOLD;
            active          <= INIT_THRESHOLD;
            pending         <= 1'b0;
            seen_frame      <= 1'b0;
            fg_count        <= '0;
            s1_vld          <= 1'b0;
            s1_fs           <= 1'b0;
            s1_pix          <= '0;
            s1_thr          <= '0;
            s1_h            <= '0;
            s1_v            <= '0;
            pixel_out       <= 1'b0;
            pixel_valid_out <= 1'b0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            ones_count_out  <= '0;
            frame_done_out  <= 1'b0;
        end else begin
            if (promote) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            // A strobe coinciding with promotion lands after the old shadow is promoted.
            if (threshold_valid_in) begin
                shadow  <= clamped;
                pending <= 1'b1;
            end

            s1_vld <= pixel_valid_in;
            s1_fs  <= pixel_valid_in && frame_start_in;
            s1_pix <= pixel_in;
            s1_thr <= thr_sel;
            s1_h   <= hcount_in;
            s1_v   <= vcount_in;

            pixel_out       <= s1_res;
            pixel_valid_out <= s1_vld;
            hcount_out      <= s1_vld ? s1_h : '0;
            vcount_out      <= s1_vld ? s1_v : '0;

            frame_done_out <= 1'b0;
            if (s1_fs) begin
                seen_frame <= 1'b1;
                fg_count   <= s1_res ? COUNT_WIDTH'(1) : '0;
                if (seen_frame) begin
                    ones_count_out <= fg_count;
                    frame_done_out <= 1'b1;
                end
            end else if (s1_res && !(&fg_count)) begin
                fg_count <= fg_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pixel_binarizer.sv
// Bench for pixel_binarizer: threshold vector table plus frame-count and reset sequences.
module tb_pixel_binarizer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [7:0]  threshold_in;
    logic        threshold_valid_in;
    logic [7:0]  pixel_in;
    logic        pixel_valid_in;
    logic        frame_start_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        pixel_out;
    logic        pixel_valid_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [7:0]  threshold_out;
    logic [7:0]  active_threshold_out;
    logic        update_pending_out;
    logic [19:0] ones_count_out;
    logic        frame_done_out;

    pixel_binarizer dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .threshold_in         (threshold_in),
        .threshold_valid_in   (threshold_valid_in),
        .pixel_in             (pixel_in),
        .pixel_valid_in       (pixel_valid_in),
        .frame_start_in       (frame_start_in),
        .hcount_in            (hcount_in),
        .vcount_in            (vcount_in),
        .pixel_out            (pixel_out),
        .pixel_valid_out      (pixel_valid_out),
        .hcount_out           (hcount_out),
        .vcount_out           (vcount_out),
        .threshold_out        (threshold_out),
        .active_threshold_out (active_threshold_out),
        .update_pending_out   (update_pending_out),
        .ones_count_out       (ones_count_out),
        .frame_done_out       (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        vld;
        logic        po;
        logic [10:0] h;
        logic [9:0]  v;
        logic        fd;
        logic [19:0] cnt;
    } out_t;

    typedef struct {
        logic        vld;
        logic        fs;
        logic [7:0]  pix;
        logic        tv;
        logic [7:0]  tin;
        logic        po;
        logic [7:0]  thr;
        logic [7:0]  act;
        logic        pend;
        logic        fd;
        logic [19:0] cnt;
    } vec_t;

    out_t exp_q[$];
    vec_t tab[14];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Drive one cycle at a negedge; the output seen one negedge later belongs to the previous step.
    task automatic step(input logic vld, input logic fs, input logic [7:0] pix,
                        input logic [10:0] h, input logic [9:0] v,
                        input logic tv, input logic [7:0] tin,
                        input logic po, input logic fd, input logic [19:0] cnt);
        out_t e;
        pixel_valid_in     = vld;
        frame_start_in     = fs;
        pixel_in           = pix;
        hcount_in          = h;
        vcount_in          = v;
        threshold_valid_in = tv;
        threshold_in       = tin;
        e.vld = vld; e.po = vld & po; e.h = h; e.v = v; e.fd = fd; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk_in);
        threshold_valid_in = 1'b0;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk("pixel_valid_out", 32'(pixel_valid_out), 32'(e.vld));
            chk("pixel_out", 32'(pixel_out), 32'(e.po));
            chk("frame_done_out", 32'(frame_done_out), 32'(e.fd));
            if (e.vld) begin
                chk("hcount_out", 32'(hcount_out), 32'(e.h));
                chk("vcount_out", 32'(vcount_out), 32'(e.v));
            end
            if (e.fd) chk("ones_count_out", 32'(ones_count_out), 32'(e.cnt));
        end
    endtask

    task automatic chk_thr(input string tag, input logic [7:0] thr, input logic [7:0] act, input logic pend);
        chk({tag, " threshold_out"}, 32'(threshold_out), 32'(thr));
        chk({tag, " active_threshold_out"}, 32'(active_threshold_out), 32'(act));
        chk({tag, " update_pending_out"}, 32'(update_pending_out), 32'(pend));
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        pixel_valid_in = 1'b0; frame_start_in = 1'b0; pixel_in = '0;
        hcount_in = '0; vcount_in = '0; threshold_valid_in = 1'b0; threshold_in = '0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        //         vld fs  pix   tv tin   po thr  act  pend fd cnt
        tab[0]  = '{1, 1, 8'd127, 0, 0,   0, 128, 128, 0, 0, 0};
        tab[1]  = '{1, 0, 8'd128, 0, 0,   1, 128, 128, 0, 0, 0};
        tab[2]  = '{1, 0, 8'd150, 1, 200, 1, 200, 128, 1, 0, 0};
        tab[3]  = '{1, 1, 8'd150, 0, 0,   0, 200, 200, 0, 1, 2};
        tab[4]  = '{0, 0, 8'd0,   1, 2,   0, 5,   200, 1, 0, 0};
        tab[5]  = '{0, 0, 8'd0,   1, 255, 0, 250, 200, 1, 0, 0};
        tab[6]  = '{0, 0, 8'd0,   1, 60,  0, 60,  200, 1, 0, 0};
        tab[7]  = '{1, 1, 8'd80,  1, 100, 1, 100, 60,  1, 1, 0};
        tab[8]  = '{1, 0, 8'd80,  0, 0,   1, 100, 60,  1, 0, 0};
        tab[9]  = '{1, 1, 8'd80,  0, 0,   0, 100, 100, 0, 1, 2};
        tab[10] = '{1, 0, 8'd100, 0, 0,   1, 100, 100, 0, 0, 0};
        tab[11] = '{0, 0, 8'd0,   1, 5,   0, 5,   100, 1, 0, 0};
        tab[12] = '{0, 0, 8'd0,   1, 250, 0, 250, 100, 1, 0, 0};
        tab[13] = '{0, 1, 8'd0,   0, 0,   0, 250, 100, 1, 0, 0};

        rst_n_in = 1'b0;
        pixel_valid_in = 1'b0; frame_start_in = 1'b0; pixel_in = '0;
        hcount_in = '0; vcount_in = '0; threshold_valid_in = 1'b0; threshold_in = '0;
        repeat (2) @(negedge clk_in);
        chk_thr("reset", 8'd128, 8'd128, 1'b0);
        chk("reset pixel_valid_out", 32'(pixel_valid_out), 0);
        chk("reset pixel_out", 32'(pixel_out), 0);
        chk("reset ones_count_out", 32'(ones_count_out), 0);
        chk("reset frame_done_out", 32'(frame_done_out), 0);
        rst_n_in = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tab[i].vld, tab[i].fs, tab[i].pix, 11'(i), 10'd3, tab[i].tv, tab[i].tin,
                 tab[i].po, tab[i].fd, tab[i].cnt);
            chk_thr($sformatf("vec%0d", i), tab[i].thr, tab[i].act, tab[i].pend);
        end
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Two 4x2 frames (3 then 8 foreground) followed by a third frame start.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 8; p++) begin
                logic fg;
                fg = (f == 1) || (p == 0) || (p == 3) || (p == 5);
                step(1, p == 0, fg ? 8'd200 : 8'd10, 11'(p % 4), 10'(p / 4), 0, 0,
                     fg, (f == 1) && (p == 0), 20'd3);
            end
        end
        step(1, 1, 8'd10, 0, 0, 0, 0, 0, 1, 20'd8);
        step(1, 0, 8'd40, 1, 0, 1, 8'd30, 0, 0, 0);
        step(1, 0, 8'd200, 2, 0, 0, 0, 1, 0, 0);
        chk_thr("pre-reset", 8'd30, 8'd128, 1'b1);

        // One-cycle reset in the middle of a stream.
        rst_n_in = 1'b0;
        pixel_valid_in = 1'b1; pixel_in = 8'd200; frame_start_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        exp_q.delete();
        chk("midreset pixel_valid_out", 32'(pixel_valid_out), 0);
        chk("midreset ones_count_out", 32'(ones_count_out), 0);
        chk_thr("midreset", 8'd128, 8'd128, 1'b0);
        step(1, 1, 8'd200, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 8'd100, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 8'd128, 0, 2, 0, 0, 1, 1, 20'd1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_binarizer.md
Name: pixel_binarizer

Overview:
- Downstream consumer of the threshold button stage.
- Holds the threshold register. A requested value is captured into a shadow register and promoted to the active register only at a frame boundary, so a frame never tears.
- Binarizes a streaming 8-bit grayscale pixel stream against the active threshold through a fixed 2-cycle pipeline.
- Counts foreground pixels per frame for the display and debug path.
- threshold_out is fed back to the button stage's threshold input, so successive presses accumulate.

Parameters:
- INIT_THRESHOLD, 128: reset value of the shadow and active thresholds.
- MIN_THRESHOLD, 5: lower clamp applied to incoming threshold requests.
- MAX_THRESHOLD, 250: upper clamp applied to incoming threshold requests.
- HWIDTH, 11: width of hcount.
- VWIDTH, 10: width of vcount.
- COUNT_WIDTH, 20: width of the foreground counter.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous, active-low reset.
- threshold_in  input  8  requested threshold.
- threshold_valid_in  input  1  single-cycle strobe qualifying threshold_in.
- pixel_in  input  8  grayscale pixel.
- pixel_valid_in  input  1  qualifies pixel_in, hcount_in, vcount_in and frame_start_in.
- frame_start_in  input  1  marks the first pixel of a frame; meaningful only with pixel_valid_in.
- hcount_in  input  HWIDTH  pixel column.
- vcount_in  input  VWIDTH  pixel row.
- pixel_out  output  1  1 = foreground (pixel at or above threshold).
- pixel_valid_out  output  1  qualifies pixel_out, hcount_out, vcount_out.
- hcount_out  output  HWIDTH  delayed hcount_in.
- vcount_out  output  VWIDTH  delayed vcount_in.
- threshold_out  output  8  shadow (latest requested) threshold, fed back to the button stage.
- active_threshold_out  output  8  threshold currently in use.
- update_pending_out  output  1  shadow differs from active and is awaiting a frame boundary.
- ones_count_out  output  COUNT_WIDTH  foreground count of the last completed frame.
- frame_done_out  output  1  one-cycle pulse when ones_count_out updates.

Behaviour:
- Clock and reset: one clock domain, clk_in. Reset is synchronous and active-low on rst_n_in, sampled at posedge clk_in.
- Reset values:
  - threshold_out and active_threshold_out = INIT_THRESHOLD.
  - All other outputs 0.
  - Foreground counter 0; "seen first frame" flag 0.
- Threshold capture: on threshold_valid_in, shadow <= clamp(threshold_in, MIN_THRESHOLD, MAX_THRESHOLD) and update_pending_out <= 1.
  - Clamping is unsigned. An 8-bit value that wrapped upstream is clamped as-is, with no wrap detection.
  - threshold_out shows the new value on the next cycle.
- Promotion: on a cycle with pixel_valid_in && frame_start_in && pending, active <= shadow and pending <= 0.
  - That same frame-start pixel is compared against the shadow value (bypass), so the whole frame uses one threshold.
- Simultaneous strobe and frame start: if threshold_valid_in coincides with an accepted frame_start_in:
  - the frame promotes the old shadow, if one was pending;
  - the new value lands in shadow with pending = 1;
  - the new value is applied at the next frame start.
- Pipeline: fixed 2-cycle latency.
  - Stage 1 registers pixel, valid, coordinates and the selected threshold.
  - Stage 2 registers pixel_out = (pixel >= threshold) and the delayed valid and coordinates.
  - Bubbles (pixel_valid_in = 0) propagate as pixel_valid_out = 0. pixel_out is 0 when invalid.
  - No backpressure.
- Foreground counter: increments at stage 2 for each valid pixel with pixel_out = 1, and saturates at all-ones.
- Frame completion: when the frame-start pixel reaches stage 2 and "seen first frame" = 1:
  - ones_count_out <= counter, and frame_done_out pulses for 1 cycle;
  - the counter restarts at (that pixel's result ? 1 : 0).
  - The first frame start after reset only sets "seen first frame" and emits no frame_done_out.
- Reset mid-frame: the pipeline is flushed (valid 0), pending is cleared and the shadow returns to INIT_THRESHOLD. The first subsequent frame start behaves as the first after reset.
- frame_start_in without pixel_valid_in is ignored.

Test Plan:
- Reset, then stream pixel 127 then 128 with no strobes: pixel_out = 0 then 1, each 2 cycles after input. threshold_out = active_threshold_out = 128.
- Mid-frame strobe threshold_in = 200, pixel 150 before the next frame start: pixel_out = 1, pending = 1. At the next frame start, pixel 150 → 0, active = 200, pending = 0.
- threshold_in = 2 → threshold_out = 5. threshold_in = 255 → threshold_out = 250.
- Strobe 100 coinciding with a frame start while shadow 60 is pending: that frame uses 60; active = 60, shadow = 100, pending = 1; the following frame uses 100.
- Two 4x2 frames with 3 and 8 foreground pixels, then a third frame start: no frame_done_out after frame 1's start; pulses with ones_count_out = 3, then 8.
- Assert rst_n_in = 0 for 1 cycle mid-stream: next cycle pixel_valid_out = 0 and thresholds = 128. The next frame start gives no frame_done_out.
